// File: rtl/cpu_trace_uart_tx_pkg.sv
// Shared types and frame layout for the CPU trace UART transmitter.
// Frame length depends on TRACE_CHECKSUM_EN (adds a trailing XOR byte).
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

`ifdef TRACE_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = 12;
`else
    localparam int unsigned FRAME_LEN = 11;
`endif

    localparam logic [3:0] IDX_SYNC  = 4'd0;
    localparam logic [3:0] IDX_PC    = 4'd1;
    localparam logic [3:0] IDX_R0    = 4'd2;
    localparam logic [3:0] IDX_FLAGS = 4'd10;
    localparam logic [3:0] IDX_CSUM  = 4'd11;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/cpu_trace_uart_tx_if.sv
// Retire-snapshot handshake between the core (master) and the trace transmitter (slave).
interface cpu_trace_uart_tx_if;

    logic        trace_valid;
    logic        trace_ready;
    logic [7:0]  pc_in;
    logic [63:0] regs_in;
    logic [3:0]  flags_in;

    modport master (
        output trace_valid, pc_in, regs_in, flags_in,
        input  trace_ready
    );

    modport slave (
        input  trace_valid, pc_in, regs_in, flags_in,
        output trace_ready
    );

endinterface

// File: rtl/cpu_trace_uart_tx_byte.sv
// 8N1 byte serializer: owns baud timing and the START/DATA/STOP sequence.
// A start asserted together with done chains the next byte with no idle gap.
module uart_tx_byte
    import cpu_trace_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       done,
    output logic       busy,
    output logic       tx
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    tx_state_t     state, state_next;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          baud_last;
    logic          load;

    assign baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        load       = 1'b0;
        tx         = 1'b1;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (baud_last) state_next = DATA;
            end
            DATA: begin
                tx = shreg[0];
                if (baud_last && bit_cnt == 3'd7) state_next = STOP;
            end
            STOP: begin
                if (baud_last) begin
                    done       = 1'b1;
                    load       = start;
                    state_next = start ? START : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            if (state == IDLE || baud_last) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (load) begin
                shreg   <= data_in;
                bit_cnt <= '0;
            end else if (state == DATA && baud_last) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/cpu_trace_uart_tx.sv
// CPU retire-snapshot trace transmitter: captures PC/R0..R7/flags and streams a UART frame.
// Optional TRACE_CHECKSUM_EN appends an XOR checksum byte over PC..flags.
module cpu_trace_uart_tx
    import cpu_trace_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_trace_uart_tx_if.slave    trace,
    output logic                  tx,
    output logic                  busy,
    output logic                  dropped,
    output logic [7:0]            drop_count
);

    logic        accept;
    logic        start;
    logic        done;
    logic        more;
    logic [3:0]  byte_idx;
    logic [3:0]  next_idx;
    logic [2:0]  reg_sel;
    logic [7:0]  byte_data;
    logic [7:0]  pc_q;
    logic [63:0] regs_q;
    logic [3:0]  flags_q;

    assign trace.trace_ready = ~busy;
    assign accept  = trace.trace_valid & trace.trace_ready;
    assign dropped = trace.trace_valid & ~trace.trace_ready;
    assign more    = (byte_idx < 4'(FRAME_LEN - 1));
    assign start   = accept | (done & more);

`ifdef TRACE_CHECKSUM_EN
    logic [7:0] csum;
    always_comb begin
        csum = pc_q ^ {4'b0, flags_q};
        for (int unsigned i = 0; i < 8; i++) begin
            csum = csum ^ regs_q[8*i +: 8];
        end
    end
`endif

    // Mux selects the byte for the index about to be loaded, so SYNC needs no snapshot.
    always_comb begin
        next_idx  = accept ? IDX_SYNC : byte_idx + 4'd1;
        reg_sel   = 3'(next_idx - IDX_R0);
        byte_data = regs_q[{reg_sel, 3'b000} +: 8];
        case (next_idx)
            IDX_SYNC:  byte_data = SYNC_BYTE;
            IDX_PC:    byte_data = pc_q;
            IDX_FLAGS: byte_data = {4'b0, flags_q};
`ifdef TRACE_CHECKSUM_EN
            IDX_CSUM:  byte_data = csum;
`endif
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            regs_q     <= '0;
            flags_q    <= '0;
            byte_idx   <= '0;
            drop_count <= '0;
        end else begin
            if (accept) begin
                pc_q    <= trace.pc_in;
                regs_q  <= trace.regs_in;
                flags_q <= trace.flags_in;
            end
            if (start) begin
                byte_idx <= next_idx;
            end
            if (dropped && drop_count != '1) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (byte_data),
        .done    (done),
        .busy    (busy),
        .tx      (tx)
    );

endmodule

// File: tb/tb_cpu_trace_uart_tx.sv
// Directed self-checking bench for cpu_trace_uart_tx at CLKS_PER_BIT=4.
module tb_cpu_trace_uart_tx;
    import cpu_trace_pkg::*;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = int'(FRAME_LEN) * 10 * CPB;
    localparam int CAP       = FRAME_CYC + 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx;
    logic       busy;
    logic       dropped;
    logic [7:0] drop_count;

    int   n_checks = 0;
    int   n_errors = 0;
    logic tx_hist [1:CAP];

    cpu_trace_uart_tx_if bus ();

    cpu_trace_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trace      (bus.slave),
        .tx         (tx),
        .busy       (busy),
        .dropped    (dropped),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: single valid pulse; 1: three extra pulses mid-frame; 2: valid held 300 busy cycles
    task automatic send_frame(input logic [7:0] pc, input logic [63:0] regs,
                              input logic [3:0] flags, input int mode, input string tag);
        logic [7:0] exp_b [FRAME_LEN];
        logic [7:0] csum;
        logic [9:0] got;
        int         n_busy;
        int         n_drop;
        int         exp_drop;
        exp_b[0]  = 8'hA5;
        exp_b[1]  = pc;
        for (int i = 0; i < 8; i++) exp_b[2 + i] = regs[8*i +: 8];
        exp_b[10] = {4'b0, flags};
        csum = '0;
        for (int i = 1; i <= 10; i++) csum = csum ^ exp_b[i];
`ifdef TRACE_CHECKSUM_EN
        exp_b[11] = csum;
`endif
        n_busy   = 0;
        n_drop   = 0;
        exp_drop = (mode == 1) ? 3 : (mode == 2) ? 300 : 0;

        @(negedge clk);
        bus.trace_valid = 1'b1;
        bus.pc_in       = pc;
        bus.regs_in     = regs;
        bus.flags_in    = flags;
        #1;
        check_eq({tag, " ready_pre"}, {63'd0, bus.trace_ready}, 64'd1);
        for (int n = 1; n <= CAP; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.pc_in    = ~pc;
                bus.regs_in  = ~regs;
                bus.flags_in = ~flags;
            end
            case (mode)
                1:       bus.trace_valid = (n == 50 || n == 150 || n == 250);
                2:       bus.trace_valid = (n <= 300);
                default: bus.trace_valid = 1'b0;
            endcase
            #1;
            tx_hist[n] = tx;
            if (busy) n_busy++;
            if (dropped) n_drop++;
            if (n == 1)
                check_eq({tag, " first_start"}, {61'd0, tx, bus.trace_ready, busy}, 64'b001);
            if (n == FRAME_CYC)
                check_eq({tag, " ready_last"}, {63'd0, bus.trace_ready}, 64'd0);
            if (n == FRAME_CYC + 1)
                check_eq({tag, " ready_back"}, {63'd0, bus.trace_ready}, 64'd1);
        end
        for (int k = 0; k < int'(FRAME_LEN); k++) begin
            for (int j = 0; j < 10; j++) got[j] = tx_hist[k*10*CPB + j*CPB + 2];
            check_eq($sformatf("%s byte%0d", tag, k), {54'd0, got}, {54'd0, 1'b1, exp_b[k], 1'b0});
        end
        check_eq({tag, " busy_len"}, 64'(n_busy), 64'(FRAME_CYC));
        check_eq({tag, " drop_pulses"}, 64'(n_drop), 64'(exp_drop));
    endtask

    initial begin
        bus.trace_valid = 1'b0;
        bus.pc_in       = '0;
        bus.regs_in     = '0;
        bus.flags_in    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            #1;
            check_eq("idle", {60'd0, tx, bus.trace_ready, busy, dropped}, 64'b1100);
        end
        check_eq("idle drop_count", {56'd0, drop_count}, 64'd0);

        send_frame(8'h12, 64'h0807_0605_0403_0201, 4'b1001, 0, "single");
        check_eq("single drop_count", {56'd0, drop_count}, 64'd0);

        send_frame(8'hC3, 64'hF0E1_D2C3_B4A5_9687, 4'b0110, 1, "pulses");
        check_eq("pulses drop_count", {56'd0, drop_count}, 64'd3);

        send_frame(8'h5A, 64'h0102_0408_1020_4080, 4'b1111, 2, "hold");
        check_eq("hold drop_count_sat", {56'd0, drop_count}, 64'd255);

        // Reset in the middle of byte 5 (R3=8'h04, data bit 1 is 0 so tx is low)
        @(negedge clk);
        bus.trace_valid = 1'b1;
        bus.pc_in       = 8'h12;
        bus.regs_in     = 64'h0807_0605_0403_0201;
        bus.flags_in    = 4'b1001;
        for (int n = 1; n <= 210; n++) begin
            @(negedge clk);
            bus.trace_valid = 1'b0;
        end
        #1;
        check_eq("rst pre_tx", {63'd0, tx}, 64'd0);
        rst = 1'b1;
        #1;
        check_eq("rst tx", {63'd0, tx}, 64'd1);
        check_eq("rst busy_ready", {62'd0, busy, bus.trace_ready}, 64'b01);
        check_eq("rst drop_count", {56'd0, drop_count}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            check_eq("post_rst idle_tx", {63'd0, tx}, 64'd1);
        end

        send_frame(8'h9E, 64'h7766_5544_3322_1100, 4'b0011, 0, "fresh");
        check_eq("fresh drop_count", {56'd0, drop_count}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
